// File: rtl/breath_led_pkg.sv
// Shared widths and direction encodings for the breathing-LED block.
package breath_led_pkg;

  localparam int CNT_US_W = 7;
  localparam int CNT_W    = 10;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/breath_led_div.sv
// Enabled modulo-MAX counter; tick marks the enabled cycle on which it wraps to zero.
module breath_led_div
  import breath_led_pkg::*;
#(
  parameter int unsigned      WIDTH = CNT_W,
  parameter logic [WIDTH-1:0] MAX   = WIDTH'(1000)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tick
);

  localparam logic [WIDTH-1:0] LAST = MAX - 1'b1;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/breath_led.sv
// Breathing PWM LED: cascaded 2us/2ms/2s counters set window position and duty.
// Define BREATH_LED_ACTIVE_LOW_EN to drive led inverted (active-low board LED).
module breath_led
  import breath_led_pkg::*;
#(
  parameter logic [CNT_US_W-1:0] CNT_2US_MAX = 7'd100,
  parameter logic [CNT_W-1:0]    CNT_2MS_MAX = 10'd1000,
  parameter logic [CNT_W-1:0]    CNT_2S_MAX  = 10'd1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic led
);

  logic [CNT_US_W-1:0] cnt_2us;
  logic [CNT_W-1:0]    cnt_2ms;
  logic [CNT_W-1:0]    cnt_2s;
  logic                tick_2us;
  logic                tick_2ms;
  logic                tick_2s;
  logic                dir;
  logic                led_on;

  breath_led_div #(.WIDTH(CNT_US_W), .MAX(CNT_2US_MAX)) u_div_2us (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .cnt  (cnt_2us),
    .tick (tick_2us)
  );

  breath_led_div #(.WIDTH(CNT_W), .MAX(CNT_2MS_MAX)) u_div_2ms (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_2us),
    .cnt  (cnt_2ms),
    .tick (tick_2ms)
  );

  breath_led_div #(.WIDTH(CNT_W), .MAX(CNT_2S_MAX)) u_div_2s (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_2ms),
    .cnt  (cnt_2s),
    .tick (tick_2s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= DIR_UP;
    end else if (tick_2s) begin
      dir <= ~dir;
    end
  end

  // cnt_2ms is the position inside the PWM window, cnt_2s sets the duty
  assign led_on = (dir == DIR_UP) ? (cnt_2ms < cnt_2s) : (cnt_2ms >= cnt_2s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef BREATH_LED_ACTIVE_LOW_EN
      led <= 1'b1;
`else
      led <= 1'b0;
`endif
    end else begin
`ifdef BREATH_LED_ACTIVE_LOW_EN
      led <= ~led_on;
`else
      led <= led_on;
`endif
    end
  end

endmodule

// File: tb/tb_breath_led.sv
// Scoreboard bench for breath_led: per-clock expected led levels from a time-based duty model.
module tb_breath_led;

  localparam int A      = 5;
  localparam int B      = 20;
  localparam int C      = 20;
  localparam int PHASE  = A * B * C;
  localparam int PERIOD = 2 * PHASE;

`ifdef BREATH_LED_ACTIVE_LOW_EN
  localparam logic LED_OFF = 1'b1;
`else
  localparam logic LED_OFF = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst_n;
  logic   led;
  int     tests = 0;
  int     fails = 0;
  int     high_cnt = 0;
  longint n = 0;
  logic   exp_q[$];

  always #5 clk = ~clk;

  breath_led #(
    .CNT_2US_MAX(7'(A)),
    .CNT_2MS_MAX(10'(B)),
    .CNT_2S_MAX (10'(C))
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .led  (led)
  );

  // Active-high LED level produced from the state reached t clocks after reset release.
  function automatic logic model(longint t);
    longint pos;
    longint win;
    longint ph;
    pos = (t / A) % B;
    win = (t / (A * B)) % C;
    ph  = (t / PHASE) % 2;
    return (ph == 0) ? (pos < win) : (pos >= win);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic e;
      e = exp_q.pop_front();
      check("led", 32'(led), 32'(e));
      if ((led ^ LED_OFF) === 1'b1) high_cnt++;
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      exp_q.push_back(model(n) ^ LED_OFF);
      n++;
      #1;
      if (n == PHASE)  check("dir_after_phase", 32'(dut.dir), 32'd1);
      if (n == PERIOD) check("dir_after_period", 32'(dut.dir), 32'd0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_led"},     32'(led),         32'(LED_OFF));
    check({tag, "_cnt_2us"}, 32'(dut.cnt_2us), 32'd0);
    check({tag, "_cnt_2ms"}, 32'(dut.cnt_2ms), 32'd0);
    check({tag, "_cnt_2s"},  32'(dut.cnt_2s),  32'd0);
    check({tag, "_dir"},     32'(dut.dir),     32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n    = 1'b1;
    n        = 0;
    high_cnt = 0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    repeat (3) begin
      @(posedge clk);
      exp_q.push_back(LED_OFF);
    end
    release_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check_reset_state("por");
    repeat (2) begin
      @(posedge clk);
      exp_q.push_back(LED_OFF);
    end
    release_reset();

    run(PERIOD);
    @(negedge clk);
    #1;
    check("high_one_period", 32'(high_cnt), 32'(A * C * C));

    run(PERIOD);
    @(negedge clk);
    #1;
    check("high_two_periods", 32'(high_cnt), 32'(2 * A * C * C));

    for (int i = 0; i < 3; i++) begin
      run(int'($urandom_range(50, 2 * PERIOD)));
      mid_reset();
    end

    run(PHASE + A * B);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
